multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 The ports SHALL be as listed below, in this order (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC register load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read request.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state, for debug.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-004 Encodings 12-15 SHALL transition to FETCH on the next clock.
REQ-005 FETCH SHALL drive iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00.
REQ-006 In FETCH, ir_write and pc_write SHALL assert only in a cycle where mem_ready=1.
REQ-007 FETCH SHALL remain in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-008 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00.
REQ-009 DECODE SHALL branch on opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BEQ; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
REQ-010 On any other opcode, DECODE SHALL pulse illegal_op=1 for that one cycle and go to FETCH.
REQ-011 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEMRD for lw or MEMWR for sw.
REQ-012 MEMRD SHALL drive iord=1 and mem_read=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-013 MEMWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-014 MEMWR SHALL drive iord=1 and mem_write=1 continuously until mem_ready=1, then go to FETCH.
REQ-015 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to ALUWB.
REQ-016 ALUWB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-017 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, branch=1 and pc_src=01, then go to FETCH.
REQ-018 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to ADDIWB.
REQ-019 ADDIWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-020 JUMP SHALL drive pc_src=10 and pc_write=1, then go to FETCH.
REQ-021 pc_en SHALL equal pc_write OR (branch AND zero).
REQ-022 Every output not listed for a state SHALL be 0 in that state.
REQ-023 All outputs SHALL be a combinational (Moore) decode of the state, qualified by mem_ready only where stated above.
REQ-024 The number of cycles per instruction SHALL be, counting mem_ready=1 on the first cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-025 Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.

Reset
REQ-026 When rst_n=0 at a clk edge, the state SHALL become FETCH, including when it occurs mid-instruction.
REQ-027 While rst_n=0, pc_en, ir_write, mem_write, mem_read, reg_write and illegal_op SHALL be forced to 0.
REQ-028 After reset, state_o SHALL be 0 and all mux selects SHALL take their FETCH values.
REQ-029 The first FETCH after reset release SHALL behave exactly as in REQ-005 to REQ-007.

Structure
REQ-030 A shared package mips_pkg SHALL hold the opcode constants, the state encodings, the alu_op encodings (shared with the ALU decoder) and the alu_src_b and pc_src encodings.
REQ-031 The design SHALL contain one state register block, one next-state block and one output-decode block, with no sub-module.
REQ-032 The ALU decoder SHALL be instantiated beside this block at the datapath level, not inside it.

Verification
REQ-033 Reset: rst_n=0 for 2 cycles with opcode=000000 -> state_o=0 and all strobes 0; after release with mem_ready=1 -> pc_en=1 and ir_write=1 in the first cycle.
REQ-034 lw with mem_ready tied to 1: opcode=100011 -> state_o sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-035 sw with stall: mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 held for 4 cycles, then FETCH.
REQ-036 beq: zero=1 -> pc_en=1 and pc_src=01 in state 8; zero=0 -> pc_en=0 and the next state is 0.
REQ-037 Illegal opcode: opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then state_o=0, with no write strobes asserted.
REQ-038 Reset mid-operation: rst_n=0 during MEMWR with mem_write=1 -> mem_write=0 in the same cycle and state_o=0 after the clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU-decoder operation codes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Also consumed by the ALU decoder that sits beside the controller.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and a
// Moore output decode, with memory handshakes qualified by mem_ready.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       mem_read,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t  r_state;
    state_t  w_next_state;

    logic    w_pc_write;
    logic    w_branch;
    logic    w_iord;
    logic    w_mem_write;
    logic    w_mem_read;
    logic    w_ir_write;
    logic    w_reg_write;
    logic    w_reg_dst;
    logic    w_mem_to_reg;
    logic    w_alu_src_a;
    logic [1:0] w_alu_src_b;
    alu_op_t w_alu_op;
    logic [1:0] w_pc_src;
    logic    w_illegal;
    logic    w_op_legal;

    assign w_op_legal = (opcode == OP_LW)   || (opcode == OP_SW)  ||
                        (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                        (opcode == OP_ADDI) || (opcode == OP_J);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_B;
        w_alu_op     = ALU_ADD;
        w_pc_src     = PCSRC_ALU;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b = SRCB_IMM_SH2;
                w_illegal   = !w_op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_SUB;
                w_branch    = 1'b1;
                w_pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by rst_n directly so they drop in the reset cycle itself.
    assign pc_en      = rst_n & (w_pc_write | (w_branch & zero));
    assign ir_write   = rst_n & w_ir_write;
    assign mem_write  = rst_n & w_mem_write;
    assign mem_read   = rst_n & w_mem_read;
    assign reg_write  = rst_n & w_reg_write;
    assign illegal_op = rst_n & w_illegal;

    assign iord       = w_iord;
    assign reg_dst    = w_reg_dst;
    assign mem_to_reg = w_mem_to_reg;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign alu_op     = w_alu_op;
    assign pc_src     = w_pc_src;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a reset/lw/beq/illegal vector table, hand
// sequences for sw stall and mid-instruction reset, then random instruction streams.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, mem_read, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, mem_write, mem_read, ir_write, reg_write;
        logic       reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        bit       rst_n;
        bit [5:0] opcode;
        bit       zero;
        bit       mem_ready;
        int       state;
        bit       pc_en, ir_write, mem_read, mem_write, reg_write, mem_to_reg, illegal;
        bit [1:0] pc_src;
    } vec_t;

    typedef int path_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rn, input bit [5:0] op, input bit z, input bit mr);
        @(negedge clk);
        rst_n = rn; opcode = op; zero = z; mem_ready = mr;
        #1;
    endtask

    function automatic obs_t actual();
        obs_t o;
        o = '{pc_en, iord, mem_write, mem_read, ir_write, reg_write, reg_dst,
              mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_o};
        return o;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Instruction phases after DECODE, straight from the instruction semantics.
    function automatic path_t route(input logic [5:0] op);
        path_t p;
        case (op)
            6'b100011: p = '{2, 3, 4};
            6'b101011: p = '{2, 5};
            6'b000000: p = '{6, 7};
            6'b000100: p = '{8};
            6'b001000: p = '{9, 10};
            6'b000010: p = '{11};
            default:   p = {};
        endcase
        return p;
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 0;
        endcase
    endfunction

    // Expected control word for a given phase; unlisted outputs stay 0.
    function automatic obs_t model_out(input int st, input logic [5:0] op,
                                       input bit z, input bit mr, input bit rn);
        obs_t o;
        bit pcw, br;
        o = '0; pcw = 0; br = 0;
        o.state = st[3:0];
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; pcw = mr; end
            1:  begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op); end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.iord = 1; o.mem_read = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.iord = 1; o.mem_write = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; br = 1; o.pc_src = 2'b01; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            10: o.reg_write = 1;
            11: begin o.pc_src = 2'b10; pcw = 1; end
            default: ;
        endcase
        o.pc_en = pcw | (br & z);
        if (!rn) begin
            o.pc_en = 0; o.ir_write = 0; o.mem_write = 0;
            o.mem_read = 0; o.reg_write = 0; o.illegal_op = 0;
        end
        return o;
    endfunction

    vec_t vecs[16];

    initial begin
        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

        //         rst op         z  mr st pce irw mrd mwr rw m2r ill pcsrc
        vecs[0]  = '{0, 6'b000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[1]  = '{0, 6'b000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[2]  = '{1, 6'b100011, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00};
        vecs[3]  = '{1, 6'b100011, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[4]  = '{1, 6'b100011, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[5]  = '{1, 6'b100011, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 2'b00};
        vecs[6]  = '{1, 6'b100011, 0, 1, 4, 0, 0, 0, 0, 1, 1, 0, 2'b00};
        vecs[7]  = '{1, 6'b000100, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00};
        vecs[8]  = '{1, 6'b000100, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[9]  = '{1, 6'b000100, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 2'b01};
        vecs[10] = '{1, 6'b000100, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00};
        vecs[11] = '{1, 6'b000100, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[12] = '{1, 6'b000100, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 2'b01};
        vecs[13] = '{1, 6'b111111, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00};
        vecs[14] = '{1, 6'b111111, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00};
        vecs[15] = '{1, 6'b111111, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 2'b00};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst_n, vecs[i].opcode, vecs[i].zero, vecs[i].mem_ready);
            check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].state));
            check($sformatf("vec%0d pc_en", i), 32'(pc_en), 32'(vecs[i].pc_en));
            check($sformatf("vec%0d ir_write", i), 32'(ir_write), 32'(vecs[i].ir_write));
            check($sformatf("vec%0d mem_read", i), 32'(mem_read), 32'(vecs[i].mem_read));
            check($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'(vecs[i].mem_write));
            check($sformatf("vec%0d reg_write", i), 32'(reg_write), 32'(vecs[i].reg_write));
            check($sformatf("vec%0d mem_to_reg", i), 32'(mem_to_reg), 32'(vecs[i].mem_to_reg));
            check($sformatf("vec%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].illegal));
            check($sformatf("vec%0d pc_src", i), 32'(pc_src), 32'(vecs[i].pc_src));
        end

        // sw with three stall cycles in MEMWR
        step(1, 6'b101011, 0, 1);
        check("sw decode", 32'(state_o), 32'd1);
        step(1, 6'b101011, 0, 1);
        check("sw memadr", 32'(state_o), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1, 6'b101011, 0, (i == 3));
            check($sformatf("sw stall%0d state", i), 32'(state_o), 32'd5);
            check($sformatf("sw stall%0d mem_write", i), 32'(mem_write), 32'd1);
            check($sformatf("sw stall%0d iord", i), 32'(iord), 32'd1);
        end
        step(1, 6'b101011, 0, 1);
        check("sw back to fetch", 32'(state_o), 32'd0);

        // reset asserted while MEMWR is stalled
        step(1, 6'b101011, 0, 1);
        check("sw2 decode", 32'(state_o), 32'd1);
        step(1, 6'b101011, 0, 0);
        check("sw2 memadr", 32'(state_o), 32'd2);
        step(1, 6'b101011, 0, 0);
        check("sw2 memwr write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst mem_write", 32'(mem_write), 32'd0);
        check("midrst state held", 32'(state_o), 32'd5);
        step(1, 6'b000000, 0, 0);
        check("midrst state after edge", 32'(state_o), 32'd0);
        check("midrst fetch stall", 32'(ir_write), 32'd0);

        // Random instruction streams against the phase model
        begin
            int        cur = 0;
            path_t     rest;
            obs_t      exp;
            int        len = 0, stalls = 0, prev_state = 0;
            bit        track = 0;
            logic [5:0] iop = 6'b111111;
            for (int n = 0; n < 4000; n++) begin
                @(negedge clk);
                rst_n     = ($urandom_range(0, 99) != 0);
                mem_ready = ($urandom_range(0, 3) != 0);
                zero      = 1'($urandom_range(0, 1));
                if (cur == 0) begin
                    case ($urandom_range(0, 7))
                        0: opcode = 6'b100011;
                        1: opcode = 6'b101011;
                        2: opcode = 6'b000000;
                        3: opcode = 6'b000100;
                        4: opcode = 6'b001000;
                        5: opcode = 6'b000010;
                        6: opcode = 6'($urandom);
                        default: opcode = 6'b100011;
                    endcase
                end
                #1;
                exp = model_out(cur, opcode, zero, mem_ready, rst_n);
                check($sformatf("rand cyc%0d outputs", n), 32'(actual()), 32'(exp));

                if (state_o == 4'd0 && prev_state != 0) begin
                    if (track && is_legal(iop))
                        check($sformatf("rand cyc%0d cpi op%b", n, iop), len, cpi(iop) + stalls);
                    len = 0; stalls = 0; track = 1;
                end
                if (state_o == 4'd1) iop = opcode;
                len++;
                if (!mem_ready && (state_o == 4'd0 || state_o == 4'd3 || state_o == 4'd5))
                    stalls++;
                if (!rst_n) track = 0;
                prev_state = int'(state_o);

                if (!rst_n) begin
                    cur = 0;
                    rest.delete();
                end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
                    cur = cur;
                end else if (cur == 0) begin
                    cur = 1;
                end else begin
                    if (cur == 1) rest = route(opcode);
                    cur = (rest.size() > 0) ? rest.pop_front() : 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
